ioctl_region_router: RTL
========================

// Module: ioctl_region_router
// PURPOSE
// Routes the data_io ROM download byte stream into NREG SDRAM write ports, one per address region.
// Packs byte pairs into 16-bit words so each word costs one SDRAM write instead of two masked writes.
// Drives each port with a toggle req/ack handshake and flushes partial words.
// Reports load completion and overflow.
// Generalises the fixed two-port, byte-per-write download path of the arcade top levels.
// PARAMETERS
// NREG        2            number of regions / SDRAM write ports (1..8)
// AW          25           ioctl_addr width
// DL_INDEX    8'h00        ioctl_index value that selects this router
// REGION_BASE {NREG{AW'0}} packed NREG*AW; region i base = [i*AW +: AW]
// REGION_SIZE {NREG{AW'0}} packed NREG*AW; region i byte length (0 = disabled)
// PORTS
// clk_sys      in   1         clock; all ioctl_* inputs are synchronous to it
// reset_n      in   1         asynchronous active-low reset
// ioctl_download in 1         download active
// ioctl_index  in   8         download target index
// ioctl_wr     in   1         byte strobe (level; the rising edge counts)
// ioctl_addr   in   AW        byte address
// ioctl_dout   in   8         byte data
// port_req     out  NREG      toggle request, one bit per region
// port_ack     in   NREG      toggle acknowledge from sdram; equals req when idle
// port_a       out  NREG*(AW-1) word address of each port = (addr-base)>>1
// port_d       out  NREG*16   write data {hi,lo}
// port_ds      out  NREG*2    byte strobes {ds_hi,ds_lo}
// busy         out  1         any word held or outstanding
// done         out  1         one-cycle pulse when the load completes
// rom_loaded   out  1         sticky after done; cleared at the start of the next matching download
// overflow     out  1         sticky; a word was dropped; cleared at the start of the next download
// BEHAVIOUR
// - Reset: all outputs 0; req=0; byte latch empty; FSM=IDLE. Async assert, sync deassert handled upstream.
// - Byte accept: ioctl_wr rises while ioctl_download=1 and ioctl_index==DL_INDEX.
//   Region = lowest i with BASE<=addr<BASE+SIZE. Bytes matching no region are ignored.
// - Packing: word key = {region, off[AW-1:1]}.
//   Even off goes to lo, odd off goes to hi; the matching ds bit is set.
//   A word commits when both ds bits are set.
//   A held partial word commits with its single ds bit when:
//     the next accepted byte has a different key;
//     the download ends;
//     the region changes.
// - Issue: a committed word loads port i a/d/ds; req[i] toggles the next cycle (1-cycle latency).
//   Port i is outstanding while req[i]!=ack[i]; a/d/ds stay stable until ack.
// - Collision: committing to a port still outstanding drops the new word, sets overflow, and keeps the port unchanged.
// - FSM states:
//   IDLE  -> LOAD on rising ioctl_download with matching index (clears rom_loaded/overflow).
//   LOAD  -> FLUSH on ioctl_download falling.
//   FLUSH : commits any partial word (1 cycle) -> DRAIN.
//   DRAIN -> DONE when req==ack for all ports.
//   DONE  : pulses done, sets rom_loaded -> IDLE.
// - Download restarting during FLUSH/DRAIN: finish DRAIN first. Bytes arriving there are still packed; the next LOAD starts from IDLE.
// - Edge cases:
//   ioctl_wr held high spans exactly one byte.
//   A byte and a commit on the same cycle are both handled.
//   SIZE=0 disables a region.
//   Overlapping regions resolve to the lowest index.
// - Widths: offset subtraction is AW bits and never negative (guarded by the compare).
//   port_a drops off[0].
// - Reset mid-download: everything returns to reset values; rom_loaded=0; no partial flush.
// TESTING
// - T1 NREG=2, BASE={0,'h100}, SIZE={'h100,'h100}; bytes 0..3 = 11,22,33,44 with ack echoing req after 3 cycles
//   -> port0 writes a=0 d=2211 ds=11, then a=1 d=4433 ds=11; exactly 2 req toggles.
// - T2 single byte at addr 'h105 = AA, then download ends
//   -> port1 a=2 d=AA00 ds=10 via FLUSH; done pulses once after the ack; rom_loaded=1.
// - T3 ack held off; two full words sent to port0
//   -> second word dropped, overflow=1, port0 keeps the first word's a/d/ds.
// - T4 byte at addr 'h300 (no region) -> no req toggle, busy=0; a different index (8'hff) -> ignored.
// - T5 reset_n low mid-DRAIN -> req=0, busy=0, rom_loaded=0, no done pulse; the next full download completes normally.
// - T6 non-contiguous bytes at offsets 0 then 4 -> port0 gets a=0 ds=01, then a=2 ds=01.

Source files
------------

// File: rtl/ioctl_region_router_if.sv
// Bus bundle for the ROM download router: data_io byte stream in, NREG toggle-handshake
// SDRAM write ports out, plus load status.
interface ioctl_region_router_if #(
    parameter int NREG = 2,
    parameter int AW   = 25
);
    logic                   ioctl_download;
    logic [7:0]             ioctl_index;
    logic                   ioctl_wr;
    logic [AW-1:0]          ioctl_addr;
    logic [7:0]             ioctl_dout;
    logic [NREG-1:0]        port_req;
    logic [NREG-1:0]        port_ack;
    logic [NREG*(AW-1)-1:0] port_a;
    logic [NREG*16-1:0]     port_d;
    logic [NREG*2-1:0]      port_ds;
    logic                   busy;
    logic                   done;
    logic                   rom_loaded;
    logic                   overflow;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, port_ack,
        input  port_req, port_a, port_d, port_ds, busy, done, rom_loaded, overflow
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, port_ack,
        output port_req, port_a, port_d, port_ds, busy, done, rom_loaded, overflow
    );
endinterface

// File: rtl/ioctl_region_router.sv
// ROM download router: packs the data_io byte stream into 16-bit words and issues them to
// one toggle req/ack SDRAM write port per address region.

// One SDRAM write port: holds a/d/ds and toggles req one cycle after a commit.
module ioctl_region_router_port #(
    parameter int AW = 25
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          commit,
    input  logic [AW-2:0] wa,
    input  logic [15:0]   wd,
    input  logic [1:0]    wds,
    input  logic          ack,
    output logic          req,
    output logic [AW-2:0] a,
    output logic [15:0]   d,
    output logic [1:0]    ds,
    output logic          busy
);
    logic          pend_q, pend_d;
    logic          req_q, req_d;
    logic [AW-2:0] a_q, a_d;
    logic [15:0]   d_q, d_d;
    logic [1:0]    ds_q, ds_d;

    always_comb begin
        pend_d = commit;
        req_d  = req_q ^ pend_q;
        a_d    = a_q;
        d_d    = d_q;
        ds_d   = ds_q;
        if (commit) begin
            a_d  = wa;
            d_d  = wd;
            ds_d = wds;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            req_q  <= 1'b0;
            a_q    <= '0;
            d_q    <= '0;
            ds_q   <= '0;
        end else begin
            pend_q <= pend_d;
            req_q  <= req_d;
            a_q    <= a_d;
            d_q    <= d_d;
            ds_q   <= ds_d;
        end
    end

    // A freshly loaded word counts as outstanding before its req toggle is visible.
    assign busy = pend_q | (req_q ^ ack);
    assign req  = req_q;
    assign a    = a_q;
    assign d    = d_q;
    assign ds   = ds_q;
endmodule

module ioctl_region_router #(
    parameter int              NREG        = 2,
    parameter int              AW          = 25,
    parameter logic [7:0]      DL_INDEX    = 8'h00,
    parameter logic [NREG*AW-1:0] REGION_BASE = '0,
    parameter logic [NREG*AW-1:0] REGION_SIZE = '0
) (
    input logic clk_sys,
    input logic reset_n,
    ioctl_region_router_if.slave io
);
    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic          wr_q, dl_q;
    logic          hold_vld_q, hold_vld_d;
    logic [RW-1:0] hold_reg_q, hold_reg_d;
    logic [AW-2:0] hold_wa_q, hold_wa_d;
    logic [15:0]   hold_d_q, hold_d_d;
    logic [1:0]    hold_ds_q, hold_ds_d;
    logic          rom_loaded_q, rom_loaded_d;
    logic          overflow_q, overflow_d;

    logic          idx_match, wr_rise, dl_rise, dl_fall, accept, start;
    logic          hit;
    logic [RW-1:0] reg_sel;
    logic [AW-1:0] off, rb, rs;
    logic          cm_vld, drop;
    logic [RW-1:0] cm_reg;
    logic [AW-2:0] cm_wa;
    logic [15:0]   cm_d, mrg_d;
    logic [1:0]    cm_ds, mrg_ds;
    logic [NREG-1:0] cm_sel, port_busy;

    logic [NREG-1:0]         req_w;
    logic [NREG-1:0][AW-2:0] a_w;
    logic [NREG-1:0][15:0]   d_w;
    logic [NREG-1:0][1:0]    ds_w;

    assign idx_match = io.ioctl_download && (io.ioctl_index == DL_INDEX);
    assign wr_rise   = io.ioctl_wr && !wr_q;
    assign dl_rise   = io.ioctl_download && !dl_q;
    assign dl_fall   = !io.ioctl_download && dl_q;
    assign accept    = wr_rise && idx_match && hit;
    assign start     = (state_q == ST_IDLE) && dl_rise && idx_match;

    // Lowest matching region wins; offset compare avoids forming BASE+SIZE, which may wrap.
    always_comb begin
        hit     = 1'b0;
        reg_sel = '0;
        off     = '0;
        rb      = '0;
        rs      = '0;
        for (int i = 0; i < NREG; i++) begin
            rb = REGION_BASE[i*AW +: AW];
            rs = REGION_SIZE[i*AW +: AW];
            if (!hit && (rs != '0) && (io.ioctl_addr >= rb) && ((io.ioctl_addr - rb) < rs)) begin
                hit     = 1'b1;
                reg_sel = RW'(i);
                off     = io.ioctl_addr - rb;
            end
        end
    end

    always_comb begin
        hold_vld_d = hold_vld_q;
        hold_reg_d = hold_reg_q;
        hold_wa_d  = hold_wa_q;
        hold_d_d   = hold_d_q;
        hold_ds_d  = hold_ds_q;
        cm_vld     = 1'b0;
        cm_reg     = hold_reg_q;
        cm_wa      = hold_wa_q;
        cm_d       = hold_d_q;
        cm_ds      = hold_ds_q;
        mrg_d      = off[0] ? {io.ioctl_dout, hold_d_q[7:0]} : {hold_d_q[15:8], io.ioctl_dout};
        mrg_ds     = hold_ds_q | (off[0] ? 2'b10 : 2'b01);
        if (accept) begin
            if (hold_vld_q && ({hold_reg_q, hold_wa_q} == {reg_sel, off[AW-1:1]})) begin
                if (&mrg_ds) begin
                    cm_vld     = 1'b1;
                    cm_d       = mrg_d;
                    cm_ds      = mrg_ds;
                    hold_vld_d = 1'b0;
                end else begin
                    hold_d_d  = mrg_d;
                    hold_ds_d = mrg_ds;
                end
            end else begin
                // New key: the held partial (if any) goes out on the same cycle the byte lands.
                cm_vld     = hold_vld_q;
                hold_vld_d = 1'b1;
                hold_reg_d = reg_sel;
                hold_wa_d  = off[AW-1:1];
                hold_d_d   = off[0] ? {io.ioctl_dout, 8'h00} : {8'h00, io.ioctl_dout};
                hold_ds_d  = off[0] ? 2'b10 : 2'b01;
            end
        end else if (hold_vld_q && ((state_q == ST_FLUSH) || dl_fall)) begin
            cm_vld     = 1'b1;
            hold_vld_d = 1'b0;
        end
    end

    always_comb begin
        cm_sel = '0;
        drop   = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (cm_vld && (cm_reg == RW'(i))) begin
                cm_sel[i] = !port_busy[i];
                drop      = drop | port_busy[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rom_loaded_d = rom_loaded_q;
        overflow_d   = overflow_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  if (!io.ioctl_download) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DRAIN;
            ST_DRAIN: if (!hold_vld_q && !accept && !(|port_busy)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (start) begin
            rom_loaded_d = 1'b0;
            overflow_d   = 1'b0;
        end
        if (state_q == ST_DONE) rom_loaded_d = 1'b1;
        if (drop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            wr_q         <= 1'b0;
            dl_q         <= 1'b0;
            hold_vld_q   <= 1'b0;
            hold_reg_q   <= '0;
            hold_wa_q    <= '0;
            hold_d_q     <= '0;
            hold_ds_q    <= '0;
            rom_loaded_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= io.ioctl_wr;
            dl_q         <= io.ioctl_download;
            hold_vld_q   <= hold_vld_d;
            hold_reg_q   <= hold_reg_d;
            hold_wa_q    <= hold_wa_d;
            hold_d_q     <= hold_d_d;
            hold_ds_q    <= hold_ds_d;
            rom_loaded_q <= rom_loaded_d;
            overflow_q   <= overflow_d;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_port
        ioctl_region_router_port #(.AW(AW)) u_port (
            .clk    (clk_sys),
            .rst_n  (reset_n),
            .commit (cm_sel[g]),
            .wa     (cm_wa),
            .wd     (cm_d),
            .wds    (cm_ds),
            .ack    (io.port_ack[g]),
            .req    (req_w[g]),
            .a      (a_w[g]),
            .d      (d_w[g]),
            .ds     (ds_w[g]),
            .busy   (port_busy[g])
        );
    end

    assign io.port_req   = req_w;
    assign io.port_a     = a_w;
    assign io.port_d     = d_w;
    assign io.port_ds    = ds_w;
    assign io.busy       = hold_vld_q | (|port_busy);
    assign io.done       = (state_q == ST_DONE);
    assign io.rom_loaded = rom_loaded_q;
    assign io.overflow   = overflow_q;
endmodule
